// File: rtl/parking_gate_fsm.sv
// Gate photo-sensor decoder: emits one inc/dec pulse per completed passage, err on illegal pattern or stall.
// Optional per-sensor debounce filter compiled in with `define PARKING_DEBOUNCE_EN.
module parking_gate_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic inc,
  output logic dec,
  output logic err,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_EN1, S_EN2, S_EN3, S_EX1, S_EX2, S_EX3, S_CLEAR
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_chk
    $error("parking_gate_fsm: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    w_ab;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tmo;
  logic          w_tmo_exp;
  logic          w_inc_nxt;
  logic          w_dec_nxt;
  logic          w_err_nxt;
  logic          w_busy_nxt;
  logic          r_inc;
  logic          r_dec;
  logic          r_err;
  logic          r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {sensor_a, sensor_b};
      r_sync <= r_meta;
    end
  end

`ifdef PARKING_DEBOUNCE_EN
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    r_filt;
  logic [DW-1:0] r_dcnt [2];

  // Output follows the synchronized input only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 2'b00;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] != r_filt[i]) begin
          if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_filt[i] <= r_sync[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 1'b1;
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  assign w_ab = r_filt;
`else
  assign w_ab = r_sync;
`endif

  assign w_tmo_exp = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      if (r_state == S_IDLE || r_state == S_CLEAR || w_state_nxt != r_state)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;
    end
  end

  // Holding pattern stays put unless the stall timer has expired; legal moves always beat the timer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        case (w_ab)
          2'b10:   w_state_nxt = S_EN1;
          2'b01:   w_state_nxt = S_EX1;
          2'b11:   w_state_nxt = S_CLEAR;
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_EN1: begin
        case (w_ab)
          2'b11:   w_state_nxt = S_EN2;
          2'b00:   w_state_nxt = S_IDLE;
          2'b10:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EN1;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_EN2: begin
        case (w_ab)
          2'b01:   w_state_nxt = S_EN3;
          2'b10:   w_state_nxt = S_EN1;
          2'b11:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EN2;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_EN3: begin
        case (w_ab)
          2'b00:   w_state_nxt = S_IDLE;
          2'b11:   w_state_nxt = S_EN2;
          2'b01:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EN3;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_EX1: begin
        case (w_ab)
          2'b11:   w_state_nxt = S_EX2;
          2'b00:   w_state_nxt = S_IDLE;
          2'b01:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EX1;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_EX2: begin
        case (w_ab)
          2'b10:   w_state_nxt = S_EX3;
          2'b01:   w_state_nxt = S_EX1;
          2'b11:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EX2;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_EX3: begin
        case (w_ab)
          2'b00:   w_state_nxt = S_IDLE;
          2'b11:   w_state_nxt = S_EX2;
          2'b10:   w_state_nxt = w_tmo_exp ? S_CLEAR : S_EX3;
          default: w_state_nxt = S_CLEAR;
        endcase
      end
      S_CLEAR: begin
        if (w_ab == 2'b00) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_inc_nxt  = (r_state == S_EN3) && (w_ab == 2'b00);
    w_dec_nxt  = (r_state == S_EX3) && (w_ab == 2'b00);
    w_err_nxt  = (w_state_nxt == S_CLEAR) && (r_state != S_CLEAR);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign inc  = r_inc;
  assign dec  = r_dec;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_parking_gate_fsm.sv
// Directed bench for parking_gate_fsm; debounce checks run only when PARKING_DEBOUNCE_EN is defined.
module tb_parking_gate_fsm;

`ifdef PARKING_DEBOUNCE_EN
  localparam int LAT  = 7;
  localparam int HOLD = 10;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 5;
`endif
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a;
  logic sensor_b;
  logic inc;
  logic dec;
  logic err;
  logic busy;

  int total = 0;
  int bad   = 0;
  int n_inc, n_dec, n_err, n_busy;
  int inc_at, dec_at, err_at;
  int busy_at_pulse;

  parking_gate_fsm #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .inc     (inc),
    .dec     (dec),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_inc = 0; n_dec = 0; n_err = 0; n_busy = 0;
    inc_at = 0; dec_at = 0; err_at = 0; busy_at_pulse = -1;
  endtask

  // Drive a pattern, then observe n cycles on falling edges; indices are 1-based within this call.
  task automatic hold(input logic [1:0] ab, input int n);
    sensor_a = ab[1];
    sensor_b = ab[0];
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (inc) begin
        n_inc++;
        if (inc_at == 0) begin inc_at = i; busy_at_pulse = int'(busy); end
      end
      if (dec) begin
        n_dec++;
        if (dec_at == 0) begin dec_at = i; busy_at_pulse = int'(busy); end
      end
      if (err) begin
        n_err++;
        if (err_at == 0) err_at = i;
      end
      n_busy += int'(busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    clr();
    hold(2'b00, 4);
    chk("idle_busy", n_busy, 0);

    // entry
    clr();
    hold(2'b10, HOLD);
    chk("entry_busy_mid", int'(busy), 1);
    hold(2'b11, HOLD);
    hold(2'b01, HOLD);
    hold(2'b00, HOLD);
    chk("entry_inc_cnt", n_inc, 1);
    chk("entry_inc_lat", inc_at, LAT);
    chk("entry_busy_at_inc", busy_at_pulse, 0);
    chk("entry_dec_cnt", n_dec, 0);
    chk("entry_err_cnt", n_err, 0);

    // exit
    clr();
    hold(2'b01, HOLD);
    hold(2'b11, HOLD);
    hold(2'b10, HOLD);
    hold(2'b00, HOLD);
    chk("exit_dec_cnt", n_dec, 1);
    chk("exit_dec_lat", dec_at, LAT);
    chk("exit_inc_cnt", n_inc, 0);
    chk("exit_err_cnt", n_err, 0);

    // entry backed out
    clr();
    hold(2'b10, HOLD);
    hold(2'b11, HOLD);
    hold(2'b10, HOLD);
    hold(2'b00, HOLD);
    chk("backout_pulses", n_inc + n_dec, 0);
    chk("backout_err", n_err, 0);
    chk("backout_idle", int'(busy), 0);

    // illegal from IDLE, then recovery
    clr();
    hold(2'b11, HOLD);
    chk("illegal_err_cnt", n_err, 1);
    chk("illegal_err_lat", err_at, LAT);
    chk("illegal_busy", int'(busy), 1);
    clr();
    hold(2'b00, HOLD);
    chk("illegal_release_busy", int'(busy), 0);
    chk("illegal_release_err", n_err, 0);
    clr();
    hold(2'b10, HOLD);
    hold(2'b11, HOLD);
    hold(2'b01, HOLD);
    hold(2'b00, HOLD);
    chk("recover_inc", n_inc, 1);
    chk("recover_err", n_err, 0);

    // simultaneous change EN1 -> 01
    clr();
    hold(2'b10, HOLD);
    hold(2'b01, HOLD);
    chk("jump_err_cnt", n_err, 1);
    chk("jump_busy", int'(busy), 1);
    clr();
    hold(2'b00, HOLD);
    chk("jump_release", int'(busy) + n_inc + n_dec, 0);

    // stall in EN1
    clr();
    hold(2'b10, LAT + TMO + 10);
    chk("tmo_err_cnt", n_err, 1);
    chk("tmo_err_at", err_at, LAT + TMO);
    chk("tmo_busy_cycles_before_err", n_busy, LAT + TMO + 10 - (LAT - 1));
    chk("tmo_clear_busy", int'(busy), 1);
    clr();
    hold(2'b00, HOLD);
    chk("tmo_release_inc", n_inc, 0);
    chk("tmo_release_busy", int'(busy), 0);

`ifdef PARKING_DEBOUNCE_EN
    // glitches shorter than the filter window
    clr();
    for (int g = 0; g < 3; g++) begin
      hold(2'b10, 3);
      hold(2'b00, 5);
    end
    chk("glitch_busy", n_busy, 0);
    chk("glitch_pulses", n_inc + n_dec + n_err, 0);
`endif

    // reset while in EN3
    clr();
    hold(2'b10, HOLD);
    hold(2'b11, HOLD);
    hold(2'b01, HOLD);
    chk("pre_rst_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pulses", int'(inc) + int'(dec) + int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
    clr();
    hold(2'b00, HOLD + 4);
    chk("post_rst_inc", n_inc, 0);
    chk("post_rst_busy", n_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
